// File: rtl/pattern_step_checker.sv
// Applies stored patterns to a same/invert buffer array one step at a time.
// Checks the returned buses at mid-step and keeps mismatch statistics for the run.
module pattern_step_checker #(
  parameter int IN_WIDTH = 10,
  parameter int PATTERNS = 8,
  parameter int ADDR_W   = 3,
  parameter int STEP     = 20,
  parameter int ERR_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [IN_WIDTH-1:0] wr_data,
  input  logic [IN_WIDTH-1:0] same_in,
  input  logic [IN_WIDTH-1:0] inv_in,
  output logic [IN_WIDTH-1:0] pat_out,
  output logic                pat_valid,
  output logic                strobe,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   cur_index,
  output logic [ERR_W-1:0]    err_count,
  output logic                first_err_valid,
  output logic [ADDR_W-1:0]   first_err_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int SW = $clog2(STEP);
  localparam logic [SW-1:0]     STEP_LAST = SW'(STEP - 1);
  localparam logic [SW-1:0]     STEP_MID  = SW'(STEP / 2);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(PATTERNS - 1);
  localparam logic [ADDR_W:0]   PAT_LIM   = (ADDR_W + 1)'(PATTERNS);
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

  logic [1:0]          state_q, state_d;
  logic [SW-1:0]       step_q, step_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [IN_WIDTH-1:0] pat_q, pat_d;
  logic                pat_valid_q, pat_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                fev_q, fev_d;
  logic [ADDR_W-1:0]   fei_q, fei_d;

  logic [IN_WIDTH-1:0] mem_q [2**ADDR_W];

  logic strobe_s;
  logic mismatch_s;
  logic mem_we_s;

  assign strobe_s   = (state_q == S_RUN) && (step_q == STEP_MID);
  assign mismatch_s = (same_in != pat_q) || (inv_in != ~pat_q);
  assign mem_we_s   = wr_en && (state_q != S_RUN) && ({1'b0, wr_addr} < PAT_LIM);

  // Pattern memory: no reset; a write racing a start lands after the mem[0] load reads it.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next-state logic for the run sequencer and the result registers.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    idx_d       = idx_q;
    pat_d       = pat_q;
    pat_valid_d = pat_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    fev_d       = fev_q;
    fei_d       = fei_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          step_d      = '0;
          idx_d       = '0;
          pat_d       = mem_q[0];
          pat_valid_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = '0;
          fev_d       = 1'b0;
          fei_d       = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        // One error per pattern, however many bits differ.
        if (strobe_s && mismatch_s) begin
          err_d = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
          if (!fev_q) begin
            fev_d = 1'b1;
            fei_d = idx_q;
          end else begin
            fev_d = fev_q;
          end
        end else begin
          err_d = err_q;
        end
        if (step_q == STEP_LAST) begin
          if (idx_q == LAST_IDX) begin
            state_d     = S_DONE;
            pat_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_d  = idx_q + ADDR_W'(1);
            pat_d  = mem_q[idx_q + ADDR_W'(1)];
            step_d = '0;
          end
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        pat_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      idx_q       <= '0;
      pat_q       <= '0;
      pat_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      fev_q       <= 1'b0;
      fei_q       <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      pat_q       <= pat_d;
      pat_valid_q <= pat_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fev_q       <= fev_d;
      fei_q       <= fei_d;
    end
  end

  assign pat_out         = pat_q;
  assign pat_valid       = pat_valid_q;
  assign strobe          = strobe_s;
  assign busy            = busy_q;
  assign done            = done_q;
  assign cur_index       = idx_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_pattern_step_checker.sv
// Directed bench: a delayed same/invert array model feeds two checkers (8-bit and 2-bit error counters).
module tb_pattern_step_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [9:0] wr_data = 10'd0;
  logic [9:0] same_in, inv_in;
  logic [9:0] pat_out;
  logic       pat_valid, strobe, busy, done, first_err_valid;
  logic [2:0] cur_index, first_err_idx;
  logic [7:0] err_count;

  logic [9:0] s_pat_out;
  logic       s_pat_valid, s_strobe, s_busy, s_done, s_fev;
  logic [2:0] s_cur_index, s_fei;
  logic [1:0] s_err_count;

  logic [9:0] hist [16];
  logic [3:0] lag_sel = 4'd4;
  int         fault_idx = -1;
  int         n_checks = 0;
  int         n_fail = 0;
  int         busy_cyc, strb_cnt, strb_bad, pat_bad;

  always #5 clk = ~clk;

  pattern_step_checker #(.IN_WIDTH(10), .PATTERNS(8), .ADDR_W(3), .STEP(20), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .same_in(same_in), .inv_in(inv_in), .pat_out(pat_out), .pat_valid(pat_valid), .strobe(strobe),
    .busy(busy), .done(done), .cur_index(cur_index), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
  );

  pattern_step_checker #(.IN_WIDTH(10), .PATTERNS(8), .ADDR_W(3), .STEP(20), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .same_in(same_in), .inv_in(inv_in), .pat_out(s_pat_out), .pat_valid(s_pat_valid), .strobe(s_strobe),
    .busy(s_busy), .done(s_done), .cur_index(s_cur_index), .err_count(s_err_count),
    .first_err_valid(s_fev), .first_err_idx(s_fei)
  );

  // Array model: hist[n] holds pat_out from n+1 cycles ago; an optional bit-3 flip on one pattern.
  always @(posedge clk) begin
    hist[0] <= pat_out;
    for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
  end
  assign same_in = hist[lag_sel];
  assign inv_in  = ~hist[lag_sel] ^ ((fault_idx >= 0 && int'(cur_index) == fault_idx) ? 10'h008 : 10'h000);

  initial begin
    for (int i = 0; i < 16; i++) hist[i] = 10'd0;
  end

  task automatic load_mem();
    logic [9:0] one;
    one = 10'd1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = one << i;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_seq(input int lag_i, input int fault_i, input int inj_k);
    logic [9:0] one;
    one = 10'd1;
    lag_sel = 4'(lag_i - 1); fault_idx = fault_i;
    busy_cyc = 0; strb_cnt = 0; strb_bad = 0; pat_bad = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 170; k++) begin
      if (busy) busy_cyc++;
      if (strobe) strb_cnt++;
      if (strobe !== ((k < 160) && (k % 20 == 10))) strb_bad++;
      if (k < 160 && (pat_valid !== 1'b1 || pat_out !== (one << (k / 20)))) pat_bad++;
      if (k == inj_k) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 10'h3FF;
      end
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (pat_out !== 10'd0) begin n_fail++; $display("FAIL reset_pat_out: got %h want 000", pat_out); end
    n_checks++; if ({pat_valid, strobe, busy, done, first_err_valid} !== 5'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {pat_valid, strobe, busy, done, first_err_valid}); end
    n_checks++; if ({cur_index, first_err_idx, err_count} !== 14'd0) begin n_fail++;
      $display("FAIL reset_counts: got idx=%0d fei=%0d err=%0d want 0", cur_index, first_err_idx, err_count); end
  endtask

  task automatic test_clean_run();
    load_mem();
    run_seq(5, -1, -1);
    n_checks++; if (busy_cyc !== 160) begin n_fail++; $display("FAIL clean_busy_cycles: got %0d want 160", busy_cyc); end
    n_checks++; if (strb_cnt !== 8) begin n_fail++; $display("FAIL clean_strobe_count: got %0d want 8", strb_cnt); end
    n_checks++; if (strb_bad !== 0) begin n_fail++; $display("FAIL clean_strobe_position: got %0d bad cycles want 0", strb_bad); end
    n_checks++; if (pat_bad !== 0) begin n_fail++; $display("FAIL clean_pattern_seq: got %0d bad cycles want 0", pat_bad); end
    n_checks++; if (done !== 1'b1 || pat_valid !== 1'b0) begin n_fail++;
      $display("FAIL clean_done: got done=%b pat_valid=%b want 1/0", done, pat_valid); end
    n_checks++; if (pat_out !== 10'h080) begin n_fail++; $display("FAIL clean_pat_held: got %h want 080", pat_out); end
    n_checks++; if (err_count !== 8'd0 || first_err_valid !== 1'b0) begin n_fail++;
      $display("FAIL clean_errors: got err=%0d fev=%b want 0/0", err_count, first_err_valid); end
  endtask

  task automatic test_single_fault();
    run_seq(5, 3, -1);
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL fault_err_count: got %0d want 1", err_count); end
    n_checks++; if (first_err_valid !== 1'b1 || first_err_idx !== 3'd3) begin n_fail++;
      $display("FAIL fault_first_err: got fev=%b idx=%0d want 1/3", first_err_valid, first_err_idx); end
    n_checks++; if (s_err_count !== 2'd1) begin n_fail++; $display("FAIL fault_err_narrow: got %0d want 1", s_err_count); end
  endtask

  task automatic test_late_lag();
    run_seq(12, -1, -1);
    n_checks++; if (err_count !== 8'd8) begin n_fail++; $display("FAIL lag_err_count: got %0d want 8", err_count); end
    n_checks++; if (first_err_valid !== 1'b1 || first_err_idx !== 3'd0) begin n_fail++;
      $display("FAIL lag_first_err: got fev=%b idx=%0d want 1/0", first_err_valid, first_err_idx); end
    n_checks++; if (s_err_count !== 2'd3) begin n_fail++; $display("FAIL lag_err_saturate: got %0d want 3", s_err_count); end
  endtask

  task automatic test_busy_ignore();
    run_seq(5, -1, 50);
    n_checks++; if (busy_cyc !== 160 || strb_cnt !== 8) begin n_fail++;
      $display("FAIL ignore_run_length: got busy=%0d strobes=%0d want 160/8", busy_cyc, strb_cnt); end
    n_checks++; if (pat_bad !== 0 || err_count !== 8'd0) begin n_fail++;
      $display("FAIL ignore_run_data: got bad=%0d err=%0d want 0/0", pat_bad, err_count); end
    run_seq(5, -1, -1);
    n_checks++; if (pat_bad !== 0) begin n_fail++; $display("FAIL ignore_mem_unchanged: got %0d bad cycles want 0", pat_bad); end
  endtask

  task automatic test_reset_mid_run();
    lag_sel = 4'd4; fault_idx = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
    end
    n_checks++; if (err_count !== 8'd1 || busy !== 1'b1) begin n_fail++;
      $display("FAIL midrst_pre: got err=%0d busy=%b want 1/1", err_count, busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({pat_valid, strobe, busy, done, first_err_valid} !== 5'b0 || pat_out !== 10'd0) begin n_fail++;
      $display("FAIL midrst_flags: got %b pat=%h want 00000/000", {pat_valid, strobe, busy, done, first_err_valid}, pat_out); end
    n_checks++; if ({cur_index, first_err_idx, err_count} !== 14'd0) begin n_fail++;
      $display("FAIL midrst_counts: got idx=%0d fei=%0d err=%0d want 0", cur_index, first_err_idx, err_count); end
    @(negedge clk); rst_n = 1'b1;
    run_seq(5, -1, -1);
    n_checks++; if (done !== 1'b1 || err_count !== 8'd0 || pat_bad !== 0) begin n_fail++;
      $display("FAIL midrst_fresh_run: got done=%b err=%0d bad=%0d want 1/0/0", done, err_count, pat_bad); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #2;
    test_reset();
    test_clean_run();
    test_single_fault();
    test_late_lag();
    test_busy_ignore();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
